alu_op_sequencer: RTL and testbench

- Controller that sequences the shared 16-bit ALU to execute word (1-pass) and long (2-pass) operations with carry chaining.
- Drives the ALU operand/op/X inputs, captures its result and flags each pass, merges flags, and returns a 32-bit result plus XNZVC.
- Sits between instruction decode (start/ready handshake) and the ALU instance.

---
 rtl/alu_op_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_op_sequencer: runs word (1-pass) / long (2-pass) ops on a shared ALU.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  output logic               o_ready,
  input  logic [2:0]         i_op,
  input  logic               i_long,
  input  logic [2*WIDTH-1:0] i_dst,
  input  logic [2*WIDTH-1:0] i_src,
  input  logic               i_x_in,
  input  logic               i_z_in,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_done,
  output logic               o_flag_x,
  output logic               o_flag_n,
  output logic               o_flag_z,
  output logic               o_flag_v,
  output logic               o_flag_c,
  output logic [WIDTH-1:0]   o_alu_a,
  output logic [WIDTH-1:0]   o_alu_b,
  output logic [2:0]         o_alu_op,
  output logic               o_alu_x,
  input  logic [WIDTH-1:0]   i_alu_o,
  input  logic               i_alu_c,
  input  logic               i_alu_z,
  input  logic               i_alu_v,
  input  logic               i_alu_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] c_OP_ADD  = 3'b000;
  localparam logic [2:0] c_OP_SUB  = 3'b001;
  localparam logic [2:0] c_OP_AND  = 3'b010;
  localparam logic [2:0] c_OP_OR   = 3'b011;
  localparam logic [2:0] c_OP_XOR  = 3'b100;
  localparam logic [2:0] c_OP_ADDX = 3'b101;
  localparam logic [2:0] c_OP_SUBX = 3'b110;

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_op;
  logic               r_long;
  logic [2*WIDTH-1:0] r_dst;
  logic [2*WIDTH-1:0] r_src;
  logic               r_x;
  logic               r_z;
  logic               r_carry;
  logic               r_zero;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_result;
  logic               r_fx, r_fn, r_fz, r_fv, r_fc;

  logic       w_extend;
  logic       w_arith;
  logic       w_final;
  logic       w_z_calc;
  logic       w_z_out;
  logic [2:0] w_alu_code;

  assign w_extend = (r_op == c_OP_ADDX) || (r_op == c_OP_SUBX);
  assign w_arith  = w_extend || (r_op == c_OP_ADD) || (r_op == c_OP_SUB);
  assign w_final  = ((r_state == S_LO) && !r_long) || (r_state == S_HI);
  // Zero must hold across both halves of a long result
  assign w_z_calc = (r_state == S_HI) ? (r_zero & i_alu_z) : i_alu_z;
  assign w_z_out  = w_extend ? (r_z & w_z_calc) : w_z_calc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_alu_code = 3'b111;
    o_alu_a    = '0;
    o_alu_b    = '0;
    o_alu_op   = 3'b000;
    o_alu_x    = 1'b0;
    case (r_op)
      c_OP_ADD, c_OP_ADDX: w_alu_code = 3'b000;
      c_OP_SUB, c_OP_SUBX: w_alu_code = 3'b001;
      c_OP_AND:            w_alu_code = 3'b010;
      c_OP_OR:             w_alu_code = 3'b011;
      c_OP_XOR:            w_alu_code = 3'b100;
      default:             w_alu_code = 3'b111;
    endcase
    case (r_state)
      S_IDLE: if (i_start) w_next = S_LO;
      S_LO: begin
        w_next   = r_long ? S_HI : S_DONE;
        o_alu_a  = r_dst[WIDTH-1:0];
        o_alu_b  = r_src[WIDTH-1:0];
        o_alu_op = w_alu_code;
        o_alu_x  = w_extend & r_x;
      end
      S_HI: begin
        w_next   = S_DONE;
        o_alu_a  = r_dst[2*WIDTH-1:WIDTH];
        o_alu_b  = r_src[2*WIDTH-1:WIDTH];
        o_alu_op = w_alu_code;
        o_alu_x  = r_carry;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_long   <= 1'b0;
      r_dst    <= '0;
      r_src    <= '0;
      r_x      <= 1'b0;
      r_z      <= 1'b0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_lo     <= '0;
      r_result <= '0;
      r_fx     <= 1'b0;
      r_fn     <= 1'b0;
      r_fz     <= 1'b0;
      r_fv     <= 1'b0;
      r_fc     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_op   <= i_op;
        r_long <= i_long;
        r_dst  <= i_dst;
        r_src  <= i_src;
        r_x    <= i_x_in;
        r_z    <= i_z_in;
      end
      if (r_state == S_LO) begin
        r_lo    <= i_alu_o;
        r_carry <= i_alu_c;
        r_zero  <= i_alu_z;
      end
      // Visible result/flags change only at completion
      if (w_final) begin
        r_result <= (r_state == S_HI) ? {i_alu_o, r_lo}
                                      : {r_dst[2*WIDTH-1:WIDTH], i_alu_o};
        r_fc     <= w_arith & i_alu_c;
        r_fv     <= w_arith & i_alu_v;
        r_fn     <= i_alu_n;
        r_fz     <= w_z_out;
        r_fx     <= w_arith ? i_alu_c : r_x;
      end
    end
  end

  assign o_ready  = (r_state == S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;
  assign o_flag_x = r_fx;
  assign o_flag_n = r_fn;
  assign o_flag_z = r_fz;
  assign o_flag_v = r_fv;
  assign o_flag_c = r_fc;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer: scoreboard bench with a 16-bit ALU stand-in and a
// 32-bit arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        lng = 1'b0;
  logic [31:0] dst = '0;
  logic [31:0] src = '0;
  logic        x_in = 1'b0;
  logic        z_in = 1'b0;
  logic        ready, done;
  logic [31:0] result;
  logic        fx, fn, fz, fv, fc;
  logic [15:0] alu_a, alu_b, alu_o;
  logic [2:0]  alu_op;
  logic        alu_x, alu_c, alu_z, alu_v, alu_n;
  logic [16:0] t_sum;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;   // {X,N,Z,V,C}
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;

  alu_op_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .i_start(start), .o_ready(ready), .i_op(op),
    .i_long(lng), .i_dst(dst), .i_src(src), .i_x_in(x_in), .i_z_in(z_in),
    .o_result(result), .o_done(done), .o_flag_x(fx), .o_flag_n(fn),
    .o_flag_z(fz), .o_flag_v(fv), .o_flag_c(fc), .o_alu_a(alu_a),
    .o_alu_b(alu_b), .o_alu_op(alu_op), .o_alu_x(alu_x), .i_alu_o(alu_o),
    .i_alu_c(alu_c), .i_alu_z(alu_z), .i_alu_v(alu_v), .i_alu_n(alu_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-bit ALU stand-in
  always_comb begin
    t_sum = '0;
    alu_o = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      3'b000: begin
        t_sum = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_x);
        alu_o = t_sum[15:0];
        alu_c = t_sum[16];
        alu_v = (alu_a[15] == alu_b[15]) && (alu_o[15] != alu_a[15]);
      end
      3'b001: begin
        t_sum = {1'b0, alu_a} - {1'b0, alu_b} - 17'(alu_x);
        alu_o = t_sum[15:0];
        alu_c = t_sum[16];
        alu_v = (alu_a[15] != alu_b[15]) && (alu_o[15] != alu_a[15]);
      end
      3'b010:  alu_o = alu_a & alu_b;
      3'b011:  alu_o = alu_a | alu_b;
      3'b100:  alu_o = alu_a ^ alu_b;
      3'b111:  alu_o = alu_a;
      default: alu_o = '0;
    endcase
    alu_z = (alu_o == 16'd0);
    alu_n = alu_o[15];
  end

  function automatic exp_t model(input logic [2:0] mop, input logic ml,
                                 input logic [31:0] d, input logic [31:0] s,
                                 input logic xi, input logic zi);
    exp_t        e;
    logic [63:0] a, b, r, mask;
    int          w;
    logic        ar, ext, cin, c, v, n, z, x;
    w    = ml ? 32 : 16;
    mask = (64'd1 << w) - 64'd1;
    a    = {32'd0, d} & mask;
    b    = {32'd0, s} & mask;
    ext  = (mop == 3'd5) || (mop == 3'd6);
    ar   = ext || (mop == 3'd0) || (mop == 3'd1);
    cin  = ext ? xi : 1'b0;
    v    = 1'b0;
    case (mop)
      3'd0, 3'd5: begin
        r = a + b + 64'(cin);
        v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'd1, 3'd6: begin
        r = a - b - 64'(cin);
        v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      default: r = a;
    endcase
    c = ar ? r[w] : 1'b0;
    v = ar ? v : 1'b0;
    r = r & mask;
    n = r[w-1];
    z = (r == 64'd0) && (ext ? zi : 1'b1);
    x = ar ? c : xi;
    e.res   = ml ? r[31:0] : {d[31:16], r[15:0]};
    e.flags = {x, n, z, v, c};
    e.due   = 0;
    return e;
  endfunction

  function automatic logic [2:0] map_op(input logic [2:0] mop);
    case (mop)
      3'd0, 3'd5: return 3'b000;
      3'd1, 3'd6: return 3'b001;
      3'd2:       return 3'b010;
      3'd3:       return 3'b011;
      3'd4:       return 3'b100;
      default:    return 3'b111;
    endcase
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", result, mon_e.res);
        chk("flags_XNZVC", {27'd0, fx, fn, fz, fv, fc}, {27'd0, mon_e.flags});
        chk("done_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic wait_drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e     = model(op, lng, dst, src, x_in, z_in);
    e.due = cyc + (lng ? 3 : 2);
    exp_q.push_back(e);
  endtask

  task automatic run_one(input logic [2:0] mop, input logic ml, input logic [31:0] d,
                         input logic [31:0] s, input logic xi, input logic zi);
    exp_t lo;
    @(negedge clk);
    for (int k = 0; k < 8 && !ready; k++) @(negedge clk);
    chk("ready_before_start", {31'd0, ready}, 32'd1);
    op = mop; lng = ml; dst = d; src = s; x_in = xi; z_in = zi; start = 1'b1;
    push_exp();
    lo = model(mop, 1'b0, d, s, xi, zi);
    @(negedge clk);
    start = 1'b0;
    dst = $urandom; src = $urandom; x_in = ~xi; z_in = ~zi; op = 3'($urandom);
    chk("lo_alu_a", {16'd0, alu_a}, {16'd0, d[15:0]});
    chk("lo_alu_b", {16'd0, alu_b}, {16'd0, s[15:0]});
    chk("lo_alu_op", {29'd0, alu_op}, {29'd0, map_op(mop)});
    chk("lo_alu_x", {31'd0, alu_x}, {31'd0, ((mop == 3'd5) || (mop == 3'd6)) & xi});
    chk("busy_ready", {31'd0, ready}, 32'd0);
    if (ml) begin
      @(negedge clk);
      chk("hi_alu_a", {16'd0, alu_a}, {16'd0, d[31:16]});
      chk("hi_alu_b", {16'd0, alu_b}, {16'd0, s[31:16]});
      chk("hi_alu_op", {29'd0, alu_op}, {29'd0, map_op(mop)});
      chk("hi_alu_x", {31'd0, alu_x}, {31'd0, lo.flags[0]});
    end
    wait_drain();
  endtask

  task automatic stream(input int n, input logic force_long);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      op = 3'($urandom); dst = rnd_word(); src = rnd_word();
      x_in = 1'($urandom); z_in = 1'($urandom);
      lng = force_long ? 1'b1 : 1'($urandom);
      start = force_long ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (ready && start) push_exp();
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {27'd0, fx, fn, fz, fv, fc}, 32'd0);
    chk("reset_alu_drive", {alu_a, alu_b}, 32'd0);
    chk("reset_alu_opx", {28'd0, alu_op, alu_x}, 32'd0);

    run_one(3'd0, 1'b0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("plan_word_add_res", result, 32'h0000_8000);
    chk("plan_word_add_flg", {27'd0, fx, fn, fz, fv, fc}, {27'd0, 5'b01010});
    run_one(3'd0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("plan_long_add_res", result, 32'h0001_0000);
    run_one(3'd1, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    chk("plan_long_sub_flg", {27'd0, fx, fn, fz, fv, fc}, {27'd0, 5'b11001});
    run_one(3'd5, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    chk("plan_addx_z1_flg", {27'd0, fx, fn, fz, fv, fc}, {27'd0, 5'b10101});
    run_one(3'd5, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    chk("plan_addx_z0_z", {31'd0, fz}, 32'd0);
    run_one(3'd2, 1'b1, 32'hF0F0_0000, 32'h0F0F_FFFF, 1'b1, 1'b0);
    chk("plan_long_and_flg", {27'd0, fx, fn, fz, fv, fc}, {27'd0, 5'b10100});
    run_one(3'd6, 1'b0, 32'hABCD_0000, 32'h0000_0000, 1'b1, 1'b1);
    run_one(3'd7, 1'b1, 32'h8000_1234, 32'h5555_5555, 1'b0, 1'b1);

    stream(40, 1'b1);
    stream(300, 1'b0);

    // Reset while the high pass is in flight
    run_one(3'd0, 1'b0, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    op = 3'd0; lng = 1'b1; dst = 32'h1234_5678; src = 32'h1111_1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_hi_busy", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_result", result, 32'd0);
    chk("midrst_flags", {27'd0, fx, fn, fz, fv, fc}, 32'd0);
    chk("midrst_alu_a", {16'd0, alu_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, done}, 32'd0);
    end
    run_one(3'd4, 1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
